// File: rtl/des_dec_iter.sv
// Iterative DES decryption core: one Feistel round per cycle, 16 cycles from accept to result.
// Optional key parity flag is built in when DES_DEC_KEY_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for din_vld; din_rdy high
// ROUND | running rounds 0..15, subkeys K16 down to K1
// DONE  | dout/dout_vld held until dout_rdy
module des_dec_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_vld,
    input  logic [63:0] din,
    input  logic [63:0] key,
    output logic        din_rdy,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic [63:0] dout,
    output logic        busy,
    output logic        key_err
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Tables hold 1-based DES bit numbers; bit 1 is the MSB of each vector.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    // One 64-bit word per S-box row, column 0 in the top nibble; index = box*4 + row.
    localparam logic [63:0] SBOX_T [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [3:0] des_sbox(input int box, input logic [5:0] six);
        logic [63:0] row_w;
        row_w = SBOX_T[box*4 + int'({six[5], six[0]})];
        return row_w[63 - 4*int'(six[4:1]) -: 4];
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r_in, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        for (int i = 0; i < 48; i++) x[47-i] = r_in[32-E_T[i]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) s[31-4*i -: 4] = des_sbox(i, x[47-6*i -: 6]);
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic [27:0] c_cur, d_cur;
    logic [31:0] f_out;

    // Walk the key schedule backwards: round 0 uses C0/D0 as loaded, later rounds rotate right.
    always_comb begin
        c_cur = c;
        d_cur = d;
        if (cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15) begin
            c_cur = {c[0], c[27:1]};
            d_cur = {d[0], d[27:1]};
        end else if (cnt != 4'd0) begin
            c_cur = {c[1:0], c[27:2]};
            d_cur = {d[1:0], d[27:2]};
        end
        f_out = f_func(r, pc2_perm({c_cur, d_cur}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            din_rdy  <= 1'b1;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            dout     <= 64'h0;
        end else begin
            case (state)
                IDLE: if (din_vld) begin
                    {l, r}  <= ip_perm(din);
                    {c, d}  <= pc1_perm(key);
                    cnt     <= 4'd0;
                    state   <= ROUND;
                    din_rdy <= 1'b0;
                    busy    <= 1'b1;
                end
                ROUND: begin
                    c   <= c_cur;
                    d   <= d_cur;
                    l   <= r;
                    r   <= l ^ f_out;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        dout     <= fp_perm({l ^ f_out, r});
                        dout_vld <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: if (dout_rdy) begin
                    dout_vld <= 1'b0;
                    din_rdy  <= 1'b1;
                    busy     <= 1'b0;
                    cnt      <= 4'd0;
                    state    <= IDLE;
                end
                default: begin
                    din_rdy  <= 1'b1;
                    dout_vld <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef DES_DEC_KEY_PARITY_EN
    // DES key bytes carry odd parity; any even byte flags the result without altering it.
    function automatic logic parity_err(input logic [63:0] k);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) if (!(^k[8*i +: 8])) err = 1'b1;
        return err;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) key_err <= 1'b0;
        else if (state == IDLE && din_vld) key_err <= parity_err(key);
        else if (state == DONE && dout_rdy) key_err <= 1'b0;
    end
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: doc/des_dec_iter.md
DES_DEC_ITER -- requirements
Module: des_dec_iter

Interface
Parameters: none.
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port din_vld, input, 1 bit: ciphertext block and key are valid.
REQ-004 SHALL have port din, input, 64 bits: ciphertext block, bit 63 = DES bit 1.
REQ-005 SHALL have port key, input, 64 bits: DES key including parity bits, bit 63 = DES bit 1.
REQ-006 SHALL have port din_rdy, output, 1 bit: block ready to accept a new input.
REQ-007 SHALL have port dout_vld, output, 1 bit: plaintext on dout is valid.
REQ-008 SHALL have port dout_rdy, input, 1 bit: downstream accepts dout.
REQ-009 SHALL have port dout, output, 64 bits: plaintext block.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port key_err, output, 1 bit: key parity error flag for the current result.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ROUND, DONE.
REQ-013 SHALL hold din_rdy = 1 only in IDLE; accept occurs on an edge where din_vld && din_rdy.
REQ-014 On accept, SHALL load L/R = IP(din), load C/D = PC1(key), clear the round counter to 0 and enter ROUND.
REQ-015 In ROUND, SHALL perform one Feistel round per cycle (E, XOR subkey, des_sbox1..des_sbox8, P), 16 rounds, counter 0..15.
REQ-016 SHALL apply subkeys in reverse order (K16 first): round 0 uses PC2(C0,D0) unrotated.
REQ-017 Before rounds 1..15, SHALL rotate C and D right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 positions respectively.
REQ-018 On the counter-15 edge, SHALL register dout = FP(R16||L16), with the final swap applied, and enter DONE.
REQ-019 SHALL assert dout_vld exactly 16 cycles after the accept edge, and only in DONE.
REQ-020 SHALL hold dout and dout_vld stable in DONE until dout_rdy = 1; that edge returns to IDLE and clears dout_vld.
REQ-021 SHALL keep din_rdy low in ROUND and in DONE; din_vld in those states SHALL be ignored, with no queuing.
REQ-022 SHALL NOT assert din_rdy in the same cycle that dout_vld is high.
REQ-023 dout SHALL retain the last result after returning to IDLE, until the next DONE.

Reset
REQ-024 When rst = 1 at an edge, SHALL enter IDLE, drive din_rdy = 1, dout_vld = 0, busy = 0, key_err = 0 and dout = 64'h0, and clear the counter.
REQ-025 Reset during ROUND or DONE SHALL abort the operation; the partial result SHALL never be presented.
REQ-026 An input presented in the first cycle after reset deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro DES_DEC_KEY_PARITY_EN SHALL control key parity checking.
REQ-028 With DES_DEC_KEY_PARITY_EN defined, SHALL sample key_err on accept as 1 if any key byte has even parity.
REQ-029 With DES_DEC_KEY_PARITY_EN defined, SHALL hold key_err with the result until leaving DONE, then clear it.
REQ-030 A key parity error SHALL NOT stop or alter decryption.
REQ-031 Without DES_DEC_KEY_PARITY_EN, key_err SHALL be constant 0 and no parity logic SHALL be synthesized.

Verification
REQ-032 Key 133457799BBCDFF1, din 85E813540F0AB405, dout_rdy=1 -> dout_vld at accept+16, dout 0123456789ABCDEF, key_err 0.
REQ-033 Key 0E329232EA6D0D73, din 0000000000000000 -> dout 8787878787878787 after 16 cycles.
REQ-034 Hold dout_rdy=0 for 5 cycles after dout_vld -> dout stable, din_rdy 0, new din_vld ignored; dout_rdy=1 -> IDLE next cycle.
REQ-035 Assert rst at round counter 7 -> next cycle IDLE, dout_vld 0, dout 0; then REQ-032 vector -> correct result.
REQ-036 With macro defined, key 123457799BBCDFF1 -> key_err 1 alongside dout_vld; without macro -> key_err 0.
REQ-037 Back-to-back: din_vld held high with REQ-032 then REQ-033 vectors, dout_rdy=1 -> second accept one cycle after the first result, both results correct.
